pucch_seq_ctrl: RTL and testbench

Sequencer for PUCCH length-12 low-PAPR sequences. On a start request it walks n = 0..11 through a combinational base-sequence lookup (group u) and adds the cyclic-shift phase alpha·n. It streams one phase index per beat, in units of 2π/24, to the downstream phase-to-IQ mapper. It repeats this for up to 14 OFDM symbols, advancing the cyclic shift per symbol.

---
 rtl/pucch_seq_pkg.sv | 15 +
 rtl/cyc_24_base_seq.sv | 47 ++++
 rtl/pucch_shift_acc.sv | 32 +++
 rtl/pucch_seq_ctrl.sv | 86 ++++++++
 tb/tb_pucch_seq_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pucch_seq_pkg.sv
// pucch_seq_pkg: shared types, constants and mod-24 helper for the PUCCH sequencer
package pucch_seq_pkg;
  localparam logic [3:0] M_ZC = 4'd12;
  localparam logic [5:0] PHASE_MOD = 6'd24;
  localparam logic [4:0] U_MAX = 5'd29;
  localparam int MAX_SYM_DEF = 14;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic [4:0] phase24_t;
  function automatic phase24_t add_mod24(input phase24_t a, input phase24_t b);
    logic [5:0] t;
    t = {1'b0, a} + {1'b0, b};
    t = (t >= PHASE_MOD) ? t - PHASE_MOD : t;
    return t[4:0];
  endfunction
endpackage

// File: rtl/cyc_24_base_seq.sv
// cyc_24_base_seq: length-12 low-PAPR base sequence phase, in units of 2*pi/24
module cyc_24_base_seq
  import pucch_seq_pkg::*;
(
  input  logic [4:0] i_u,
  input  logic [3:0] i_n,
  output phase24_t   o_base
);
  // phi(n) in units of pi/4; phase24 = 3*phi mod 24
  localparam int PHI [30][12] = '{
    '{-3,  1, -3, -3, -3,  3, -3, -1,  1,  1,  1, -3},
    '{-3,  3,  1, -3,  1,  3, -1, -1,  1,  3,  3,  3},
    '{-3,  3,  3,  1, -3,  3, -1,  1,  3, -3,  3, -3},
    '{-3, -3, -1,  3,  3,  3, -3,  3, -3,  1, -1, -3},
    '{-3, -1, -1,  1,  3,  1,  1, -1,  1, -1, -3,  1},
    '{-3, -3,  3,  1, -3, -3, -3, -1,  3, -1,  1,  3},
    '{ 1, -1,  3, -1, -1, -1, -3, -1,  1,  1,  1, -3},
    '{-1, -3,  3, -1, -3, -3, -3, -1,  1, -1,  1, -3},
    '{-3, -1,  3,  1, -3, -1, -3,  3,  1,  3,  3,  1},
    '{-3, -1, -1, -3, -3, -1, -3,  3,  1,  3, -1, -3},
    '{-3,  3, -3,  3,  3, -3, -1, -1,  3,  3,  1, -3},
    '{-3, -1, -3, -1, -1, -3,  3,  3, -1, -1,  1, -3},
    '{-3, -1,  3, -3, -3, -1, -3,  1, -1, -3,  3,  3},
    '{-3,  1, -1, -1,  3,  3, -3, -1, -1, -3, -1, -3},
    '{ 1,  3, -3,  1,  3,  3,  3,  1, -1,  1, -1,  3},
    '{-3,  1,  3, -1, -1, -3, -3, -1, -1,  3,  1, -3},
    '{-1, -1, -1, -1,  1, -3, -1,  3,  3, -1, -3,  1},
    '{-1,  1,  1, -1,  1,  3,  3, -1, -1, -3,  1, -3},
    '{-3,  1,  3,  3, -1, -1, -3,  3,  3, -3,  3, -3},
    '{-3, -3,  3, -3, -1,  3,  3,  3, -1, -3,  1, -3},
    '{ 3,  1,  3,  1,  3, -3, -1,  1,  3,  1, -1, -3},
    '{-3,  3,  1,  3, -3,  1,  1,  1,  1,  3, -3,  3},
    '{-3,  3,  3,  3, -1, -3, -3, -1, -3,  1,  3, -3},
    '{ 3, -1, -3,  3, -3, -1,  3,  3,  3, -3, -1, -3},
    '{-3, -1,  1, -3,  1,  3,  3,  3, -1, -3,  3,  3},
    '{-3,  3,  1, -1,  3,  3, -3,  1, -1,  1, -1,  1},
    '{-1,  1,  3, -3,  1, -1,  1, -1, -1, -3,  1, -1},
    '{-3, -3,  3,  3,  3, -3, -1,  1, -3,  3,  1, -3},
    '{ 1, -1,  3,  1,  1, -1, -1, -1,  1,  3, -3,  1},
    '{-3,  3, -3,  3, -3, -3,  3, -1, -1,  1,  3, -3}
  };
  int p;
  always_comb begin
    p = PHI[(i_u > U_MAX) ? 5'd0 : i_u][(i_n >= M_ZC) ? 4'd0 : i_n];
    o_base = (p == 1) ? 5'd3 : (p == 3) ? 5'd9 : (p == -3) ? 5'd15 : 5'd21;
  end
endmodule

// File: rtl/pucch_shift_acc.sv
// pucch_shift_acc: cyclic-shift state m (mod 12) and running phase ramp s (mod 24)
module pucch_shift_acc
  import pucch_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_init,
  input  logic [3:0] i_m,
  input  logic       i_adv,
  input  logic       i_wrap,
  input  logic [3:0] i_step,
  output phase24_t   o_s
);
  logic [3:0] m_q, m_next;
  logic [4:0] m_sum;
  phase24_t s_q;
  assign m_sum = {1'b0, m_q} + {1'b0, i_step};
  assign m_next = (m_sum >= {1'b0, M_ZC}) ? 4'(m_sum - {1'b0, M_ZC}) : m_sum[3:0];
  assign o_s = s_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_q <= '0;
      s_q <= '0;
    end else if (i_init) begin
      m_q <= i_m;
      s_q <= '0;
    end else if (i_wrap) begin
      m_q <= m_next;
      s_q <= '0;
    end else if (i_adv) s_q <= add_mod24(s_q, {m_q, 1'b0});
  end
endmodule

// File: rtl/pucch_seq_ctrl.sv
// pucch_seq_ctrl: streams 12-element PUCCH phase indices per symbol with cyclic-shift hopping
module pucch_seq_ctrl
  import pucch_seq_pkg::*;
#(
  parameter int PHASE_W = 5,
  parameter int MAX_SYM = MAX_SYM_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [4:0]         i_u,
  input  logic [3:0]         i_m_cs,
  input  logic [3:0]         i_m_step,
  input  logic [3:0]         i_num_sym,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PHASE_W-1:0] o_phase_24,
  output logic [3:0]         o_n,
  output logic [3:0]         o_sym,
  output logic               o_last
);
  localparam logic [3:0] MAX_SYM_L = 4'(MAX_SYM);
  state_t state_q, state_d;
  logic [4:0] u_q;
  logic [3:0] step_q, nsym_q, n_q, sym_q, on_q, osym_q;
  logic valid_q, last_q, err_q, legal, start_ok, load, end_sym, last_beat;
  phase24_t base, s, phase_q;
  assign legal = (i_u <= U_MAX) && (i_m_cs < M_ZC) && (i_m_step < M_ZC) &&
                 (i_num_sym != 4'd0) && (i_num_sym <= MAX_SYM_L);
  assign start_ok = (state_q == IDLE) && i_start && legal;
  // the output register refills whenever it is empty or being drained this cycle
  assign load = (state_q == RUN) && (!valid_q || i_ready);
  assign end_sym = n_q == M_ZC - 4'd1;
  assign last_beat = end_sym && (sym_q == nsym_q - 4'd1);
  cyc_24_base_seq u_base (.i_u(u_q), .i_n(n_q), .o_base(base));
  pucch_shift_acc u_acc (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(start_ok), .i_m(i_m_cs),
    .i_adv(load && !end_sym), .i_wrap(load && end_sym), .i_step(step_q), .o_s(s)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_ok ? RUN : IDLE;
      RUN:     state_d = (load && last_beat) ? DRAIN : RUN;
      DRAIN:   state_d = i_ready ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      {u_q, step_q, nsym_q, n_q, sym_q, on_q, osym_q} <= '0;
      {valid_q, last_q, err_q} <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= (state_q == IDLE) && i_start && !legal;
      if (start_ok) begin
        u_q <= i_u;
        step_q <= i_m_step;
        nsym_q <= i_num_sym;
        n_q <= '0;
        sym_q <= '0;
      end
      if (load) begin
        phase_q <= add_mod24(base, s);
        on_q <= n_q;
        osym_q <= sym_q;
        last_q <= last_beat;
        valid_q <= 1'b1;
        n_q <= end_sym ? 4'd0 : n_q + 4'd1;
        sym_q <= end_sym ? sym_q + 4'd1 : sym_q;
      end
      if (state_q == DRAIN && i_ready) valid_q <= 1'b0;
    end
  end
  assign o_busy = state_q != IDLE;
  assign o_err = err_q;
  assign o_valid = valid_q;
  assign o_phase_24 = PHASE_W'(phase_q);
  assign o_n = on_q;
  assign o_sym = osym_q;
  assign o_last = last_q;
endmodule

// File: tb/tb_pucch_seq_ctrl.sv
// tb_pucch_seq_ctrl: directed checks of the PUCCH sequencer against a closed-form phase model
module tb_pucch_seq_ctrl;
  logic clk = 1'b0;
  logic rst, start, busy, err, valid, ready, last;
  logic [4:0] u, phase;
  logic [3:0] m_cs, m_step, num_sym, n, sym;
  int total = 0, bad = 0, cyc = 0, start_cyc = 0;
  bit seen;
  typedef struct {int ph; int n; int sym; int last;} beat_t;
  beat_t exp_q[$];
  int cap[$], ref_cap[$];
  int lit1[12] = '{15, 3, 15, 15, 15, 9, 15, 21, 3, 3, 3, 15};
  int lit2[12] = '{15, 5, 19, 21, 23, 19, 3, 11, 19, 21, 23, 13};
  int lit3[12] = '{15, 1, 11, 9, 7, 23, 3, 7, 11, 9, 7, 17};
  localparam int PHI [30][12] = '{
    '{-3,  1, -3, -3, -3,  3, -3, -1,  1,  1,  1, -3},
    '{-3,  3,  1, -3,  1,  3, -1, -1,  1,  3,  3,  3},
    '{-3,  3,  3,  1, -3,  3, -1,  1,  3, -3,  3, -3},
    '{-3, -3, -1,  3,  3,  3, -3,  3, -3,  1, -1, -3},
    '{-3, -1, -1,  1,  3,  1,  1, -1,  1, -1, -3,  1},
    '{-3, -3,  3,  1, -3, -3, -3, -1,  3, -1,  1,  3},
    '{ 1, -1,  3, -1, -1, -1, -3, -1,  1,  1,  1, -3},
    '{-1, -3,  3, -1, -3, -3, -3, -1,  1, -1,  1, -3},
    '{-3, -1,  3,  1, -3, -1, -3,  3,  1,  3,  3,  1},
    '{-3, -1, -1, -3, -3, -1, -3,  3,  1,  3, -1, -3},
    '{-3,  3, -3,  3,  3, -3, -1, -1,  3,  3,  1, -3},
    '{-3, -1, -3, -1, -1, -3,  3,  3, -1, -1,  1, -3},
    '{-3, -1,  3, -3, -3, -1, -3,  1, -1, -3,  3,  3},
    '{-3,  1, -1, -1,  3,  3, -3, -1, -1, -3, -1, -3},
    '{ 1,  3, -3,  1,  3,  3,  3,  1, -1,  1, -1,  3},
    '{-3,  1,  3, -1, -1, -3, -3, -1, -1,  3,  1, -3},
    '{-1, -1, -1, -1,  1, -3, -1,  3,  3, -1, -3,  1},
    '{-1,  1,  1, -1,  1,  3,  3, -1, -1, -3,  1, -3},
    '{-3,  1,  3,  3, -1, -1, -3,  3,  3, -3,  3, -3},
    '{-3, -3,  3, -3, -1,  3,  3,  3, -1, -3,  1, -3},
    '{ 3,  1,  3,  1,  3, -3, -1,  1,  3,  1, -1, -3},
    '{-3,  3,  1,  3, -3,  1,  1,  1,  1,  3, -3,  3},
    '{-3,  3,  3,  3, -1, -3, -3, -1, -3,  1,  3, -3},
    '{ 3, -1, -3,  3, -3, -1,  3,  3,  3, -3, -1, -3},
    '{-3, -1,  1, -3,  1,  3,  3,  3, -1, -3,  3,  3},
    '{-3,  3,  1, -1,  3,  3, -3,  1, -1,  1, -1,  1},
    '{-1,  1,  3, -3,  1, -1,  1, -1, -1, -3,  1, -1},
    '{-3, -3,  3,  3,  3, -3, -1,  1, -3,  3,  1, -3},
    '{ 1, -1,  3,  1,  1, -1, -1, -1,  1,  3, -3,  1},
    '{-3,  3, -3,  3, -3, -3,  3, -1, -1,  1,  3, -3}
  };

  pucch_seq_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_u(u), .i_m_cs(m_cs),
    .i_m_step(m_step), .i_num_sym(num_sym), .o_busy(busy), .o_err(err),
    .o_valid(valid), .i_ready(ready), .o_phase_24(phase), .o_n(n),
    .o_sym(sym), .o_last(last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // phase of element nn for cyclic shift m: 3*phi(u,nn) + 2*m*nn, mod 24
  task automatic build_model(input int uu, input int mcs, input int mstep, input int nsym);
    exp_q.delete();
    for (int s = 0; s < nsym; s++)
      for (int nn = 0; nn < 12; nn++)
        exp_q.push_back('{(PHI[uu][nn] * 3 + 48 + 2 * ((mcs + s * mstep) % 12) * nn) % 24,
                          nn, s, int'(s == nsym - 1 && nn == 11)});
  endtask

  task automatic compare();
    if (rst || !valid) return;
    if (!seen) begin
      seen = 1;
      check("first_beat_latency", cyc - start_cyc, 2);
    end
    if (exp_q.size() == 0) begin
      check("unexpected_beat", 1, 0);
      return;
    end
    check("phase", int'(phase), exp_q[0].ph);
    check("n", int'(n), exp_q[0].n);
    check("sym", int'(sym), exp_q[0].sym);
    check("last", int'(last), exp_q[0].last);
    if (ready) begin
      cap.push_back(int'(phase));
      void'(exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input int uu, input int mcs, input int mstep, input int nsym,
                         input bit rnd, input bit poke_busy, input bit poke_end);
    int nb;
    build_model(uu, mcs, mstep, nsym);
    nb = exp_q.size();
    cap.delete();
    seen = 0;
    u = 5'(uu); m_cs = 4'(mcs); m_step = 4'(mstep); num_sym = 4'(nsym);
    ready = 1'b1;
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 3000 && !(exp_q.size() == 0 && !busy); k++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke_busy && k == 4) || (poke_end && cyc == start_cyc + nb + 1);
      u = (poke_busy && k == 4) ? 5'd31 : 5'(uu);
      step();
      check("err_quiet_while_busy", int'(err), 0);
    end
    start = 1'b0;
    ready = 1'b1;
    check("beats_remaining", exp_q.size(), 0);
    check("busy_after_request", int'(busy), 0);
    check("valid_after_request", int'(valid), 0);
    if (!rnd) check("cycles_start_to_idle", cyc - start_cyc, nb + 2);
  endtask

  task automatic err_start(input string name, input int uu, input int mcs, input int mstep,
                           input int nsym);
    u = 5'(uu); m_cs = 4'(mcs); m_step = 4'(mstep); num_sym = 4'(nsym);
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, "_err_pulse"}, int'(err), 1);
    check({name, "_busy"}, int'(busy), 0);
    step();
    check({name, "_err_cleared"}, int'(err), 0);
    check({name, "_no_beat"}, int'(valid), 0);
    check({name, "_still_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    u = '0; m_cs = '0; m_step = '0; num_sym = 4'd1;
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_n", int'(n), 0);
    check("rst_sym", int'(sym), 0);
    check("rst_last", int'(last), 0);
    rst = 1'b0;
    step();

    run_req(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) check("vec1_literal", cap[i], lit1[i]);
    step();
    step();
    check("start_at_final_handshake_ignored", int'(busy), 0);
    check("no_beat_after_ignored_start", int'(valid), 0);

    run_req(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) check("vec2_literal", cap[i], lit2[i]);

    run_req(0, 11, 2, 2, 0, 1, 0);
    for (int i = 0; i < 12; i++) check("vec3_sym0_literal", cap[i], lit3[i]);
    for (int i = 0; i < 12; i++) check("vec3_sym1_literal", cap[12 + i], lit2[i]);

    run_req(5, 3, 7, 14, 0, 0, 0);
    ref_cap = cap;
    run_req(5, 3, 7, 14, 1, 0, 0);
    check("random_ready_beat_count", cap.size(), 168);
    begin
      int diff = 0;
      for (int i = 0; i < 168 && i < cap.size(); i++) diff += int'(cap[i] != ref_cap[i]);
      check("random_ready_matches_fixed", diff, 0);
    end
    run_req(29, 11, 11, 3, 1, 1, 0);

    err_start("u30", 30, 0, 0, 1);
    err_start("mcs12", 0, 12, 0, 1);
    err_start("step12", 0, 0, 12, 1);
    err_start("nsym0", 0, 0, 0, 0);
    err_start("nsym15", 0, 0, 0, 15);

    build_model(0, 0, 0, 1);
    cap.delete();
    seen = 0;
    u = '0; m_cs = '0; m_step = '0; num_sym = 4'd1;
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 50 && cap.size() < 5; k++) step();
    check("beats_before_reset", cap.size(), 5);
    rst = 1'b1;
    exp_q.delete();
    step();
    check("midrst_valid", int'(valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_phase", int'(phase), 0);
    check("midrst_n", int'(n), 0);
    check("midrst_last", int'(last), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("no_beat_after_reset", int'(valid), 0);
    end
    run_req(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) check("vec1_after_reset", cap[i], lit1[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
